data_mem_port: RTL and testbench

//   Load/store unit feeding the ReadData leg of the write-back result select.
//   - Takes MemRead/MemWrite, Funct3, ALUResult (address) and WriteData from the core.
//   - Runs one valid/ready transaction on the data-memory bus.
//   - Returns a sign/zero-extended load word on ReadData.
//   - Stalls the core while the access is in flight.

---
 rtl/data_mem_port_if.sv | 24 ++
 rtl/data_mem_port.sv | 169 ++++++++++++++++
 tb/tb_data_mem_port.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_port_if.sv
// Data-memory bus bundle: one valid/ready request channel with byte strobes.
// master = load/store unit, slave = memory.
interface data_mem_port_if #(
    parameter int N = 32
);
    logic           BusValid;
    logic           BusWe;
    logic [N-1:0]   BusAddr;
    logic [N-1:0]   BusWData;
    logic [N/8-1:0] BusWStrb;
    logic           BusReady;
    logic [N-1:0]   BusRData;
    logic           BusErr;

    modport master (
        output BusValid, BusWe, BusAddr, BusWData, BusWStrb,
        input  BusReady, BusRData, BusErr
    );

    modport slave (
        input  BusValid, BusWe, BusAddr, BusWData, BusWStrb,
        output BusReady, BusRData, BusErr
    );
endinterface

// File: rtl/data_mem_port.sv
// Load/store unit: one bus transaction per access, stalls the core, extends load data.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into MemErr.
module data_mem_port #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    Funct3,
    input  logic [N-1:0]  ALUResult,
    input  logic [N-1:0]  WriteData,
    output logic [N-1:0]  ReadData,
    output logic          Stall,
    output logic          MemErr,
    data_mem_port_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_reg, state_next;
    logic [N-1:0]   addr_reg;
    logic [1:0]     addr_lo_reg;
    logic [2:0]     funct3_reg;
    logic           we_reg;
    logic [N-1:0]   wdata_reg;
    logic [N/8-1:0] wstrb_reg;
    logic [N-1:0]   rdata_reg;
    logic           err_reg;
    logic [CW-1:0]  cnt_reg;

    logic           request;
    logic           f3_ok;
    logic           misalign;
    logic           bad_req;
    logic           timeout_hit;
    logic [N-1:0]   st_data;
    logic [N/8-1:0] st_strb;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [N-1:0]   ld_ext;

    assign request     = MemRead | MemWrite;
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

    // Stores accept only B/H/W; loads also accept BU/HU.
    always_comb begin
        if (MemWrite)
            f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        else
            f3_ok = (Funct3 != 3'b011) && (Funct3[2:1] != 2'b11);
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                      ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_req = !f3_ok || misalign;

    // Per-lane store data replication and strobe decode.
    generate
        for (genvar gi = 0; gi < N / 8; gi++) begin : g_lane
            assign st_data[gi*8 +: 8] =
                (Funct3[1:0] == 2'b00) ? WriteData[7:0] :
                (Funct3[1:0] == 2'b01) ? WriteData[(gi % 2)*8 +: 8] :
                                         WriteData[gi*8 +: 8];
            assign st_strb[gi] =
                (Funct3[1:0] == 2'b00) ? (ALUResult[1:0] == 2'(gi)) :
                (Funct3[1:0] == 2'b01) ? (ALUResult[1] == 1'((gi / 2) % 2)) :
                                         1'b1;
        end
    endgenerate

    assign ld_byte = bus.BusRData[{addr_lo_reg, 3'b000} +: 8];
    assign ld_half = addr_lo_reg[1] ? bus.BusRData[31:16] : bus.BusRData[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  ld_ext = {{(N-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(N-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(N-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(N-16){1'b0}}, ld_half};
            default: ld_ext = bus.BusRData;
        endcase
    end

    // Stall is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        state_next   = state_reg;
        Stall        = 1'b0;
        bus.BusValid = 1'b0;
        case (state_reg)
            IDLE: begin
                Stall = request & rst_n;
                if (request)
                    state_next = bad_req ? DONE : REQ;
            end
            REQ: begin
                Stall        = 1'b1;
                bus.BusValid = 1'b1;
                if (bus.BusReady || timeout_hit)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            addr_lo_reg <= '0;
            funct3_reg  <= '0;
            we_reg      <= 1'b0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (request) begin
                        addr_reg    <= {ALUResult[N-1:2], 2'b00};
                        addr_lo_reg <= ALUResult[1:0];
                        funct3_reg  <= Funct3;
                        we_reg      <= MemWrite;
                        wdata_reg   <= st_data;
                        wstrb_reg   <= MemWrite ? st_strb : '0;
                        if (bad_req) begin
                            err_reg   <= 1'b1;
                            rdata_reg <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (bus.BusReady) begin
                        err_reg <= bus.BusErr;
                        if (bus.BusErr)
                            rdata_reg <= '0;
                        else if (!we_reg)
                            rdata_reg <= ld_ext;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    assign ReadData     = rdata_reg;
    assign MemErr       = err_reg;
    assign bus.BusWe    = we_reg;
    assign bus.BusAddr  = addr_reg;
    assign bus.BusWData = wdata_reg;
    assign bus.BusWStrb = wstrb_reg;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: vector table of single accesses plus
// hand-written timeout, one-cycle MemErr and mid-transaction reset sequences.
module tb_data_mem_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemErr;

    int n_pass = 0;
    int n_total = 0;

    data_mem_port_if #(.N(32)) bus();

    data_mem_port #(.N(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemErr    (MemErr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rbus;
        bit          berr;
        int          waits;      // -1: BusReady never asserted
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_nstall;
        int          exp_nvalid;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        else
            n_pass++;
    endtask

    // Starts at posedge+1, ends at posedge+1 after the DONE cycle.
    task automatic access(input vec_t v, output int nstall, output int nvalid,
                          output logic err, output logic [31:0] rdo, output logic cwe,
                          output logic [31:0] caddr, output logic [31:0] cwd,
                          output logic [3:0] cstrb);
        bit done;
        int cyc;
        MemRead      = v.rd;
        MemWrite     = v.wr;
        Funct3       = v.f3;
        ALUResult    = v.addr;
        WriteData    = v.wd;
        bus.BusRData = v.rbus;
        bus.BusErr   = v.berr;
        bus.BusReady = 1'b0;
        nstall = 0; nvalid = 0; err = 1'b0; rdo = '0;
        cwe = 1'b0; caddr = '0; cwd = '0; cstrb = '0;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 64) begin
            if (bus.BusValid) begin
                nvalid++;
                cwe   = bus.BusWe;
                caddr = bus.BusAddr;
                cwd   = bus.BusWData;
                cstrb = bus.BusWStrb;
                bus.BusReady = (v.waits >= 0) && (nvalid > v.waits);
            end else begin
                bus.BusReady = 1'b0;
            end
            @(negedge clk);
            if (Stall) nstall++;
            else begin
                done = 1'b1;
                err  = MemErr;
                rdo  = ReadData;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        bus.BusReady = 1'b0;
        chk("access_completes", 32'(done), 32'd1);
    endtask

    initial begin
        int nstall, nvalid;
        logic err, cwe;
        logic [31:0] rdo, caddr, cwd;
        logic [3:0] cstrb;
        vec_t t;

        //          rd wr f3      addr          wd            rbus         be w  exp_rd        er st vl we exp_addr      strb     exp_wd
        vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 32'hFFFFFF80, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 32'h00000080, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0, 0, 32'h000080FF, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[4]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 0, 0, 32'hFFFF80FF, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[5]  = '{0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        0, 0, 32'hFFFF80FF, 0, 2, 1, 1, 32'h100, 4'b0010, 32'hABABABAB};
        vecs[6]  = '{0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0,        0, 0, 32'hFFFF80FF, 0, 2, 1, 1, 32'h100, 4'b1100, 32'h12341234};
        vecs[7]  = '{0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        0, 2, 32'hFFFF80FF, 0, 4, 3, 1, 32'h204, 4'b1111, 32'hCAFEF00D};
        vecs[8]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 1, 32'h0000007F, 0, 3, 2, 0, 32'h100, 4'b0000, 32'h0};
        vecs[9]  = '{0, 1, 3'b100, 32'h010, 32'h0,        32'h0,        0, 0, 32'h00000000, 1, 1, 0, 0, 32'h0,   4'b0000, 32'h0};
        vecs[10] = '{1, 0, 3'b101, 32'h100, 32'h0,        32'h0000ABCD, 0, 0, 32'h0000ABCD, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[11] = '{1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 0, 32'h00000000, 1, 1, 0, 0, 32'h0,   4'b0000, 32'h0};
        vecs[12] = '{1, 0, 3'b100, 32'h102, 32'h0,        32'h00C30000, 0, 0, 32'h000000C3, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
        vecs[13] = '{1, 0, 3'b010, 32'h108, 32'h0,        32'h12345678, 1, 0, 32'h00000000, 1, 2, 1, 0, 32'h108, 4'b0000, 32'h0};
        vecs[14] = '{1, 1, 3'b010, 32'h300, 32'h55AA55AA, 32'h0,        0, 0, 32'h00000000, 0, 2, 1, 1, 32'h300, 4'b1111, 32'h55AA55AA};
`ifdef MISALIGN_TRAP_EN
        vecs[15] = '{1, 0, 3'b001, 32'h201, 32'h0,        32'h0000F00F, 0, 0, 32'h00000000, 1, 1, 0, 0, 32'h0,   4'b0000, 32'h0};
        vecs[16] = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h11223344, 0, 0, 32'h00000000, 1, 1, 0, 0, 32'h0,   4'b0000, 32'h0};
`else
        vecs[15] = '{1, 0, 3'b001, 32'h201, 32'h0,        32'h0000F00F, 0, 0, 32'hFFFFF00F, 0, 2, 1, 0, 32'h200, 4'b0000, 32'h0};
        vecs[16] = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h11223344, 0, 0, 32'h11223344, 0, 2, 1, 0, 32'h100, 4'b0000, 32'h0};
`endif

        bus.BusReady = 1'b0;
        bus.BusRData = '0;
        bus.BusErr   = 1'b0;

        // Reset state, with a request already presented by the core
        MemRead = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_stall", 32'(Stall), 32'd0);
        chk("reset_valid", 32'(bus.BusValid), 32'd0);
        chk("reset_readdata", ReadData, 32'h0);
        chk("reset_memerr", 32'(MemErr), 32'd0);
        chk("reset_strb", 32'(bus.BusWStrb), 32'd0);
        MemRead = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            access(vecs[i], nstall, nvalid, err, rdo, cwe, caddr, cwd, cstrb);
            $display("vec %0d: rd=%0d wr=%0d f3=%03b addr=0x%08h -> ReadData=0x%08h MemErr=%0d stall=%0d valid=%0d strb=%04b",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, rdo, err, nstall, nvalid, cstrb);
            chk($sformatf("v%0d_readdata", i), rdo, vecs[i].exp_rd);
            chk($sformatf("v%0d_memerr", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_stall_cycles", i), 32'(nstall), 32'(vecs[i].exp_nstall));
            chk($sformatf("v%0d_valid_cycles", i), 32'(nvalid), 32'(vecs[i].exp_nvalid));
            if (vecs[i].exp_nvalid > 0) begin
                chk($sformatf("v%0d_we", i), 32'(cwe), 32'(vecs[i].exp_we));
                chk($sformatf("v%0d_addr", i), caddr, vecs[i].exp_addr);
                chk($sformatf("v%0d_strb", i), 32'(cstrb), 32'(vecs[i].exp_strb));
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d_wdata", i), cwd, vecs[i].exp_wd);
            end
        end

        // Timeout: BusReady never comes, preceded by a good load so ReadData must clear
        t = vecs[0];
        access(t, nstall, nvalid, err, rdo, cwe, caddr, cwd, cstrb);
        t.waits = -1;
        t.addr  = 32'h500;
        access(t, nstall, nvalid, err, rdo, cwe, caddr, cwd, cstrb);
        $display("timeout: valid=%0d stall=%0d MemErr=%0d ReadData=0x%08h", nvalid, nstall, err, rdo);
        chk("timeout_valid_cycles", 32'(nvalid), 32'd16);
        chk("timeout_stall_cycles", 32'(nstall), 32'd17);
        chk("timeout_memerr", 32'(err), 32'd1);
        chk("timeout_readdata", rdo, 32'h0);
        @(negedge clk);
        chk("memerr_one_cycle", 32'(MemErr), 32'd0);
        chk("idle_no_valid", 32'(bus.BusValid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of REQ
        t = vecs[0];
        access(t, nstall, nvalid, err, rdo, cwe, caddr, cwd, cstrb);
        MemRead = 1'b1;
        Funct3 = 3'b010;
        ALUResult = 32'h400;
        bus.BusReady = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midreq_valid_before", 32'(bus.BusValid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-REQ reset: BusValid=%0d Stall=%0d ReadData=0x%08h", bus.BusValid, Stall, ReadData);
        chk("midreq_valid", 32'(bus.BusValid), 32'd0);
        chk("midreq_stall", 32'(Stall), 32'd0);
        chk("midreq_readdata", ReadData, 32'h0);
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = vecs[0];
        t.addr = 32'h104;
        t.rbus = 32'hA5A5A5A5;
        access(t, nstall, nvalid, err, rdo, cwe, caddr, cwd, cstrb);
        $display("post-reset LW: ReadData=0x%08h MemErr=%0d stall=%0d", rdo, err, nstall);
        chk("postreset_readdata", rdo, 32'hA5A5A5A5);
        chk("postreset_addr", caddr, 32'h104);
        chk("postreset_stall_cycles", 32'(nstall), 32'd2);
        chk("postreset_memerr", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
